univ_shift_reg: RTL and testbench
=================================

Name: univ_shift_reg

Overview:
Parametrised universal shift register that generalises the team's 4-bit serial-in/parallel-out register. Supports:
- Configurable WIDTH.
- Four operating modes: hold, shift-left, shift-right and parallel load.
- A synchronous clear.
- A bit counter that raises a word_valid strobe each time WIDTH fresh bits have been shifted in.

It serves as the common SIPO/PISO/deserialiser building block for the serial-link and UART practice designs.

Parameters:
WIDTH, 8, register width in bits; legal range is 2 to 64.
CNT_W, $clog2(WIDTH+1), width of the bit counter; derived and not overridden by users.

Ports:
clk  input  1  rising-edge clock
rst  input  1  reset; synchronous and active-low (asserted = 0)
en  input  1  operation enable; when 0 the register and counter hold
clr  input  1  synchronous clear of register, counter and strobe
mode  input  2  00 hold, 01 shift-right, 10 shift-left, 11 parallel load
serial_in  input  1  serial data bit shifted in
parallel_in  input  WIDTH  data for parallel load
parallel_out  output  WIDTH  current register contents
serial_out_msb  output  1  equals parallel_out[WIDTH-1]; this is the bit lost on a left shift
serial_out_lsb  output  1  equals parallel_out[0]; this is the bit lost on a right shift
bit_cnt  output  CNT_W  number of bits shifted in since the last load, clear or word boundary
word_valid  output  1  one-cycle strobe marking that a full word has been assembled

Behaviour:
- All state updates occur on the rising edge of clk. Per-edge priority, highest first:
  1. rst==0
  2. clr==1
  3. en==0
  4. mode
- Reset (rst==0 at an edge):
  - parallel_out = 0, bit_cnt = 0, word_valid = 0.
  - Reset asserted mid-word discards all partial data.
  - The first operation after release is accepted on the first edge at which rst==1.
- clr==1: same effect as reset but under functional control. clr is ignored when en==0? No: clr takes priority over en.
- en==0: register and bit_cnt hold, and word_valid is driven 0.
- mode 00 (hold): register and bit_cnt unchanged; word_valid 0.
- mode 01 (shift-right):
  - reg <= {serial_in, reg[WIDTH-1:1]}, so serial_in enters at the MSB and the LSB is discarded.
- mode 10 (shift-left):
  - reg <= {reg[WIDTH-2:0], serial_in}, so serial_in enters at the LSB (legacy SIPO direction) and the MSB is discarded.
- Bit counting on any shift (mode 01 or 10 with en==1):
  - If bit_cnt == WIDTH-1: bit_cnt <= 0 and word_valid <= 1 in the same edge. The strobe is therefore visible in the cycle in which parallel_out first shows the complete word.
  - Otherwise: bit_cnt <= bit_cnt+1 and word_valid <= 0.
- mode 11 (parallel load):
  - reg <= parallel_in, bit_cnt <= 0, word_valid <= 0.
  - A load in the middle of a word restarts framing.
- Strobe and output timing:
  - word_valid is registered and stays high for exactly one cycle unless the next edge completes another word. This is only possible when WIDTH==1, which is illegal.
  - serial_out_msb and serial_out_lsb are combinational taps of the register, so there is no extra latency.
- Direction changes: switching between mode 01 and mode 10 mid-word is legal. The counter keeps counting shifts regardless of direction.
- Register latency: a shifted-in bit appears in parallel_out one edge after it is sampled.
- No X propagation from unused inputs: parallel_in is ignored in every mode except 11, and serial_in is ignored in modes 00 and 11.

Decomposition:
- Shared include header (Verilog `define constants): USR_MODE_HOLD=2'b00, USR_MODE_SHR=2'b01, USR_MODE_SHL=2'b10, USR_MODE_LOAD=2'b11.
- Other serial-link blocks import these constants rather than redefining them.
- One natural sub-module, shift_bit_counter, parameterised by MAX=WIDTH. Its interface:
  - Inputs: inc, restart.
  - Outputs: count, wrap.
  - It also owns the word_valid register.
- The data register and mode mux stay in univ_shift_reg.

Test Plan:
1. Reset: WIDTH=4, drive rst=0 for 2 edges while mode=11 and parallel_in=4'hF -> parallel_out=0, bit_cnt=0, word_valid=0. Then release rst -> the next edge with mode=11 loads 4'hF.
2. SIPO shift-left: WIDTH=4, en=1, mode=10, serial_in sequence 1,0,1,1 -> parallel_out goes 0001, 0010, 0101, 1011; word_valid=1 only in the cycle showing 1011; bit_cnt reads 1, 2, 3, 0.
3. PISO shift-right with output tap: load 4'b1001, then mode=01 with serial_in=0 for 4 edges -> serial_out_lsb reads 1, 0, 0, 1 (sampled before each edge) and parallel_out ends at 0000. word_valid pulses on the 4th shift.
4. Hold and enable: mid-word at bit_cnt=2, apply en=0 for 3 edges, then mode=00 for 2 edges -> register and bit_cnt unchanged, word_valid=0 throughout. Resuming shifts completes the word after 2 more shifts.
5. Priority and restart: at bit_cnt=3, assert clr=1 together with mode=10 -> parallel_out=0, bit_cnt=0, no word_valid. Separately, a load at bit_cnt=2 -> bit_cnt=0, and the next word_valid comes only after 4 further shifts.
6. Width generality: rerun scenarios 2 and 3 with WIDTH=8 and WIDTH=2 -> word_valid arrives every 8 and every 2 shifts respectively; continuous shifting produces evenly spaced one-cycle strobes with no gaps.

Source files
------------

// File: rtl/univ_shift_reg_pkg.sv
// Shared constants for the universal shift register and the serial-link
// blocks that drive it. Mode encodings live here so no block redefines them.
package univ_shift_reg_pkg;

  typedef enum logic [1:0] {
    USR_MODE_HOLD = 2'b00,
    USR_MODE_SHR  = 2'b01,
    USR_MODE_SHL  = 2'b10,
    USR_MODE_LOAD = 2'b11
  } usr_mode_e;

endpackage

// File: rtl/univ_shift_reg_shift_bit_counter.sv
// Bit counter for shift framing: counts shifted-in bits modulo MAX and owns
// the registered one-cycle word strobe. 'wrap' is that registered strobe,
// high in the cycle after the edge that consumed the MAX-th bit.
module shift_bit_counter #(
  parameter int unsigned MAX   = 8,
  parameter int unsigned CNT_W = $clog2(MAX + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             restart,
  output logic [CNT_W-1:0] count,
  output logic             wrap
);

  logic [CNT_W-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;

  // Next count/strobe: restart wins over a shift; strobe defaults low.
  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    if (restart) begin
      count_d = '0;
    end else if (inc) begin
      if (count_q == CNT_W'(MAX - 1)) begin
        count_d = '0;
        wrap_d  = 1'b1;
      end else begin
        count_d = count_q + CNT_W'(1);
      end
    end
  end

  // Counter and strobe registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  assign count = count_q;
  assign wrap  = wrap_q;

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register: hold, shift-right, shift-left and parallel load,
// with synchronous clear and word framing via shift_bit_counter.
module univ_shift_reg
  import univ_shift_reg_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [1:0]       mode,
  input  logic             serial_in,
  input  logic [WIDTH-1:0] parallel_in,
  output logic [WIDTH-1:0] parallel_out,
  output logic             serial_out_msb,
  output logic             serial_out_lsb,
  output logic [CNT_W-1:0] bit_cnt,
  output logic             word_valid
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             shift;
  logic             restart;

  // Mode mux: clr beats en, en beats mode; loads and clears restart framing.
  always_comb begin
    data_d  = data_q;
    shift   = 1'b0;
    restart = 1'b0;
    if (clr) begin
      data_d  = '0;
      restart = 1'b1;
    end else if (en) begin
      case (usr_mode_e'(mode))
        USR_MODE_SHR: begin
          data_d = {serial_in, data_q[WIDTH-1:1]};
          shift  = 1'b1;
        end
        USR_MODE_SHL: begin
          data_d = {data_q[WIDTH-2:0], serial_in};
          shift  = 1'b1;
        end
        USR_MODE_LOAD: begin
          data_d  = parallel_in;
          restart = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Data register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) data_q <= '0;
    else      data_q <= data_d;
  end

  shift_bit_counter #(
    .MAX   (WIDTH),
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk     (clk),
    .rst     (rst),
    .inc     (shift),
    .restart (restart),
    .count   (bit_cnt),
    .wrap    (word_valid)
  );

  assign parallel_out   = data_q;
  assign serial_out_msb = data_q[WIDTH-1];
  assign serial_out_lsb = data_q[0];

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed bench for univ_shift_reg at WIDTH 4, 8 and 2 sharing one control bus.
module tb_univ_shift_reg;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en  = 1'b1;
  logic       clr = 1'b0;
  logic [1:0] mode = 2'b11;
  logic       sin = 1'b0;
  logic [3:0] pin4 = 4'hF;
  logic [7:0] pin8 = '0;
  logic [1:0] pin2 = '0;

  logic [3:0] po4;  logic msb4, lsb4, wv4;  logic [2:0] cnt4;
  logic [7:0] po8;  logic msb8, lsb8, wv8;  logic [3:0] cnt8;
  logic [1:0] po2;  logic msb2, lsb2, wv2;  logic [1:0] cnt2;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  univ_shift_reg #(.WIDTH(4)) u4 (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .mode(mode), .serial_in(sin),
    .parallel_in(pin4), .parallel_out(po4), .serial_out_msb(msb4),
    .serial_out_lsb(lsb4), .bit_cnt(cnt4), .word_valid(wv4));

  univ_shift_reg #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .mode(mode), .serial_in(sin),
    .parallel_in(pin8), .parallel_out(po8), .serial_out_msb(msb8),
    .serial_out_lsb(lsb8), .bit_cnt(cnt8), .word_valid(wv8));

  univ_shift_reg #(.WIDTH(2)) u2 (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .mode(mode), .serial_in(sin),
    .parallel_in(pin2), .parallel_out(po2), .serial_out_msb(msb2),
    .serial_out_lsb(lsb2), .bit_cnt(cnt2), .word_valid(wv2));

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one edge; outputs are then sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    clr = 1'b1;
    step();
    clr = 1'b0;
  endtask

  task automatic check4(input string tag, input logic [3:0] p, input logic [2:0] c, input logic v);
    check_val({tag, ".po"}, 64'(po4), 64'(p));
    check_val({tag, ".cnt"}, 64'(cnt4), 64'(c));
    check_val({tag, ".wv"}, 64'(wv4), 64'(v));
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [3:0] bits_a [4];
    logic [3:0] po_a   [4];
    logic [7:0] m8;
    logic [1:0] m2;
    logic [7:0] pat8;
    logic [1:0] pat2;

    // 1. Reset held for two edges while a load is requested
    step(); step();
    check4("reset", 4'h0, 3'd0, 1'b0);
    check_val("reset.po8", 64'(po8), 64'h0);
    rst = 1'b1;
    step();
    check4("load_after_rst", 4'hF, 3'd0, 1'b0);

    // 2. SIPO shift-left 1,0,1,1
    do_clear();
    check4("clr", 4'h0, 3'd0, 1'b0);
    bits_a = '{4'd1, 4'd0, 4'd1, 4'd1};
    po_a   = '{4'h1, 4'h2, 4'h5, 4'hB};
    mode = 2'b10;
    for (int i = 0; i < 4; i++) begin
      sin = bits_a[i][0];
      step();
      check4($sformatf("sipo%0d", i), po_a[i], 3'((i + 1) % 4), 1'(i == 3));
    end
    check_val("sipo.msb", 64'(msb4), 64'h1);

    // 3. PISO shift-right of 1001 watching the LSB tap
    mode = 2'b11; pin4 = 4'b1001;
    step();
    check4("piso_load", 4'h9, 3'd0, 1'b0);
    mode = 2'b01; sin = 1'b0;
    po_a = '{4'h4, 4'h2, 4'h1, 4'h0};
    bits_a = '{4'd1, 4'd0, 4'd0, 4'd1};
    for (int i = 0; i < 4; i++) begin
      check_val($sformatf("piso_lsb%0d", i), 64'(lsb4), 64'(bits_a[i][0]));
      step();
      check4($sformatf("piso%0d", i), po_a[i], 3'((i + 1) % 4), 1'(i == 3));
    end

    // 4. Hold via en=0 and mode 00 mid-word
    do_clear();
    mode = 2'b10; sin = 1'b1;
    step(); step();
    check4("hold_pre", 4'h3, 3'd2, 1'b0);
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check4($sformatf("en0_%0d", i), 4'h3, 3'd2, 1'b0);
    end
    en = 1'b1; mode = 2'b00;
    for (int i = 0; i < 2; i++) begin
      step();
      check4($sformatf("mode00_%0d", i), 4'h3, 3'd2, 1'b0);
    end
    mode = 2'b10; sin = 1'b0;
    step();
    check4("resume0", 4'h6, 3'd3, 1'b0);
    step();
    check4("resume1", 4'hC, 3'd0, 1'b1);
    mode = 2'b00;
    step();
    check4("strobe_drop", 4'hC, 3'd0, 1'b0);

    // 5. clr beats shift, clr beats en=0, load restarts framing, reset mid-word
    do_clear();
    mode = 2'b10; sin = 1'b1;
    step(); step(); step();
    check4("pri_pre", 4'h7, 3'd3, 1'b0);
    clr = 1'b1;
    step();
    clr = 1'b0;
    check4("clr_vs_shift", 4'h0, 3'd0, 1'b0);
    step();
    en = 1'b0; clr = 1'b1;
    step();
    en = 1'b1; clr = 1'b0;
    check4("clr_vs_en", 4'h0, 3'd0, 1'b0);
    sin = 1'b1;
    step(); step();
    check4("ld_pre", 4'h3, 3'd2, 1'b0);
    mode = 2'b11; pin4 = 4'h5;
    step();
    check4("ld_mid", 4'h5, 3'd0, 1'b0);
    mode = 2'b10; sin = 1'b0;
    po_a = '{4'hA, 4'h4, 4'h8, 4'h0};
    for (int i = 0; i < 4; i++) begin
      step();
      check4($sformatf("ld_shift%0d", i), po_a[i], 3'((i + 1) % 4), 1'(i == 3));
    end
    sin = 1'b1;
    step(); step();
    rst = 1'b0;
    step();
    rst = 1'b1;
    check4("rst_mid", 4'h0, 3'd0, 1'b0);

    // 6a. Continuous shift-left at WIDTH 8 and 2
    do_clear();
    m8 = '0; m2 = '0;
    pat8 = 8'b1101_0011;
    mode = 2'b10;
    for (int i = 0; i < 16; i++) begin
      sin = pat8[i % 8];
      m8 = {m8[6:0], sin};
      m2 = {m2[0], sin};
      step();
      check_val($sformatf("w8_po%0d", i), 64'(po8), 64'(m8));
      check_val($sformatf("w8_cnt%0d", i), 64'(cnt8), 64'((i + 1) % 8));
      check_val($sformatf("w8_wv%0d", i), 64'(wv8), 64'(i % 8 == 7));
      check_val($sformatf("w2_po%0d", i), 64'(po2), 64'(m2));
      check_val($sformatf("w2_cnt%0d", i), 64'(cnt2), 64'((i + 1) % 2));
      check_val($sformatf("w2_wv%0d", i), 64'(wv2), 64'(i % 2 == 1));
    end

    // 6b. PISO shift-right at WIDTH 8 and 2
    pat8 = 8'hA5; pat2 = 2'b10;
    mode = 2'b11; pin8 = pat8; pin2 = pat2;
    step();
    check_val("w8_load", 64'(po8), 64'hA5);
    check_val("w2_load", 64'(po2), 64'h2);
    mode = 2'b01; sin = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check_val($sformatf("w8_lsb%0d", i), 64'(lsb8), 64'(pat8[i]));
      if (i < 2) check_val($sformatf("w2_lsb%0d", i), 64'(lsb2), 64'(pat2[i]));
      step();
      check_val($sformatf("w8_pwv%0d", i), 64'(wv8), 64'(i == 7));
      check_val($sformatf("w2_pwv%0d", i), 64'(wv2), 64'(i % 2 == 1));
    end
    check_val("w8_empty", 64'(po8), 64'h0);
    check_val("w2_empty", 64'(po2), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
